// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: sweeps {a,b} through 00,01,10,11, checks the 7 returned gate outputs, tallies mismatches.
// Optional feature macro: GATE_SWEEP_ABORT_ON_FAIL_EN (stop the sweep at the first mismatch).
module gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic [6:0]       gate_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       first_fail_vec,
  output logic [6:0]       first_fail_mask
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int PW = $clog2(NUM_PASSES + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  state_t state;
  logic [SW-1:0] settle_cnt;
  logic [PW-1:0] pass_idx;
  logic [6:0] exp_v, diff;
  logic [CNT_W-1:0] err_next;
  logic miss, last, stop;
  // expected gate outputs for the driven vector and the sweep-exit decision
  always_comb begin
    exp_v = {a_out & b_out, a_out | b_out, ~a_out, ~(a_out & b_out), ~(a_out | b_out), a_out ^ b_out, ~(a_out ^ b_out)};
    diff = exp_v ^ gate_in;
    miss = |diff;
    err_next = (miss && err_count != '1) ? err_count + CNT_W'(1) : err_count;
    last = {a_out, b_out} == 2'b11 && pass_idx == PW'(NUM_PASSES - 1);
`ifdef GATE_SWEEP_ABORT_ON_FAIL_EN
    stop = last || miss;
`else
    stop = last;
`endif
  end
  // sweep sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_out <= 1'b0;
      b_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      first_fail_vec <= '0;
      first_fail_mask <= '0;
      settle_cnt <= '0;
      pass_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            {a_out, b_out} <= 2'b00;
            pass_idx <= '0;
            settle_cnt <= '0;
            err_count <= '0;
            first_fail_vec <= '0;
            first_fail_mask <= '0;
            pass <= 1'b0;
            busy <= 1'b1;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + SW'(1);
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state <= SAMPLE;
        end
        SAMPLE: begin
          err_count <= err_next;
          if (miss && err_count == '0) begin
            first_fail_vec <= {a_out, b_out};
            first_fail_mask <= diff;
          end
          if (stop) begin
            done <= 1'b1;
            busy <= 1'b0;
            pass <= err_next == '0;
            state <= DONE;
          end else begin
            {a_out, b_out} <= {a_out, b_out} + 2'd1;
            if ({a_out, b_out} == 2'b11) pass_idx <= pass_idx + PW'(1);
            settle_cnt <= '0;
            state <= SETTLE;
          end
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: scoreboard bench for gate_sweep_checker, default instance plus a 3-pass 2-bit-counter instance.
module tb_gate_sweep_checker;
  logic clk = 0, rst = 1;
  logic [1:0] st = '0;
  logic [1:0] a_o, b_o, busy_o, done_o, pass_o;
  logic [7:0] ec0;
  logic [1:0] ec1;
  logic [1:0] ffv [2];
  logic [6:0] ffm [2];
  logic [6:0] gin [2];
  logic [6:0] s0 = '0, s1 = '0;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic [7:0] ec;
    logic pass;
    logic [1:0] fv;
    logic [6:0] fm;
    int cyc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [6:0] good(input logic a, input logic b);
    logic [6:0] g;
    g[6] = a & b;
    g[5] = a | b;
    g[4] = !a;
    g[3] = !(a && b);
    g[2] = !(a || b);
    g[1] = a != b;
    g[0] = a == b;
    return g;
  endfunction

  always_comb begin
    gin[0] = (good(a_o[0], b_o[0]) & ~s0) | s1;
    gin[1] = (good(a_o[1], b_o[1]) & ~s0) | s1;
  end

  gate_sweep_checker dut0 (
    .clk(clk), .rst(rst), .start(st[0]), .a_out(a_o[0]), .b_out(b_o[0]), .gate_in(gin[0]),
    .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .err_count(ec0),
    .first_fail_vec(ffv[0]), .first_fail_mask(ffm[0]));

  gate_sweep_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(3), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .a_out(a_o[1]), .b_out(b_o[1]), .gate_in(gin[1]),
    .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .err_count(ec1),
    .first_fail_vec(ffv[1]), .first_fail_mask(ffm[1]));

  function automatic exp_t model(input int u);
    exp_t e;
    int np, mx, k;
    bit stop;
    np = u ? 3 : 1;
    mx = u ? 3 : 255;
    k = 0;
    stop = 0;
    e.ec = 0; e.fv = 0; e.fm = 0;
    for (int p = 0; p < np; p++)
      for (int v = 0; v < 4; v++)
        if (!stop) begin
          logic [1:0] vv;
          logic [6:0] g, d;
          vv = 2'(v);
          g = good(vv[1], vv[0]);
          d = g ^ ((g & ~s0) | s1);
          k++;
          if (d != 0) begin
            if (e.ec == 0) begin e.fv = vv; e.fm = d; end
            if (int'(e.ec) < mx) e.ec++;
`ifdef GATE_SWEEP_ABORT_ON_FAIL_EN
            stop = 1;
`endif
          end
        end
    e.cyc = k * 3;
    e.pass = e.ec == 0;
    return e;
  endfunction

  function automatic logic [7:0] ec_of(input int u);
    return u ? {6'b0, ec1} : ec0;
  endfunction

  // start is already high; the next posedge accepts it
  task automatic track(input int u, input bit hold);
    bit got;
    int n;
    exp_t e;
    got = 0;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (n == 0 && !hold) st[u] = 0;
      if (done_o[u]) begin got = 1; break; end
      n_cmp++;
      if ({a_o[u], b_o[u], busy_o[u]} !== {2'((n / 3) % 4), 1'b1}) begin
        n_bad++;
        $display("FAIL vec u=%0d n=%0d got ab=%b%b busy=%b want ab=%b busy=1", u, n, a_o[u], b_o[u], busy_o[u], 2'((n / 3) % 4));
      end
    end
    e = sb.pop_front();
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL timeout u=%0d no done within %0d cycles, want done at %0d", u, n, e.cyc);
    end else if (n !== e.cyc || ec_of(u) !== e.ec || pass_o[u] !== e.pass || ffv[u] !== e.fv || ffm[u] !== e.fm || busy_o[u] !== 1'b0) begin
      n_bad++;
      $display("FAIL result u=%0d got cyc=%0d ec=%0d pass=%b fv=%b fm=%b busy=%b want cyc=%0d ec=%0d pass=%b fv=%b fm=%b busy=0",
               u, n, ec_of(u), pass_o[u], ffv[u], ffm[u], busy_o[u], e.cyc, e.ec, e.pass, e.fv, e.fm);
    end
  endtask

  task automatic run(input int u, input logic [6:0] f0, input logic [6:0] f1);
    s0 = f0;
    s1 = f1;
    sb.push_back(model(u));
    @(negedge clk);
    st[u] = 1;
    track(u, 0);
  endtask

  task automatic check_zero(input string name, input int u);
    n_cmp++;
    if ({a_o[u], b_o[u], busy_o[u], done_o[u], pass_o[u], ec_of(u), ffv[u], ffm[u]} !== '0) begin
      n_bad++;
      $display("FAIL %s u=%0d got ab=%b%b busy=%b done=%b pass=%b ec=%0d fv=%b fm=%b want all 0",
               name, u, a_o[u], b_o[u], busy_o[u], done_o[u], pass_o[u], ec_of(u), ffv[u], ffm[u]);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    check_zero("reset", 0);
    check_zero("reset", 1);
    rst = 0;
  endtask

  task automatic test_clean();
    run(0, 7'b0, 7'b0);
    @(negedge clk);
    n_cmp++;
    if (done_o[0] !== 1'b0 || pass_o[0] !== 1'b1 || busy_o[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL post_done got done=%b pass=%b busy=%b want done=0 pass=1 busy=0", done_o[0], pass_o[0], busy_o[0]);
    end
  endtask

  task automatic test_xor_stuck0();
    run(0, 7'b0000010, 7'b0);
  endtask

  task automatic test_saturate();
    run(1, 7'b0, 7'b0010000);
  endtask

  task automatic test_and_stuck1();
    run(0, 7'b0, 7'b1000000);
  endtask

  task automatic test_back_to_back();
    s0 = '0;
    s1 = '0;
    sb.push_back(model(0));
    @(negedge clk);
    st[0] = 1;
    track(0, 1);
    sb.push_back(model(0));
    @(negedge clk);
    n_cmp++;
    if (busy_o[0] !== 1'b0 || done_o[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL done_start_ignored got busy=%b done=%b want busy=0 done=0", busy_o[0], done_o[0]);
    end
    track(0, 0);
  endtask

  task automatic test_mid_reset();
    s0 = 7'b0000010;
    s1 = '0;
    @(negedge clk);
    st[0] = 1;
    for (int n = 0; n <= 8; n++) begin
      @(negedge clk);
      if (n == 0) st[0] = 0;
    end
    n_cmp++;
    if ({a_o[0], b_o[0]} !== 2'b10 || ec0 !== 8'd1) begin
      n_bad++;
      $display("FAIL pre_reset got ab=%b%b ec=%0d want ab=10 ec=1", a_o[0], b_o[0], ec0);
    end
    rst = 1;
    @(negedge clk);
    check_zero("mid_reset", 0);
    rst = 0;
    run(0, 7'b0, 7'b0);
  endtask

  initial begin
    test_reset();
    test_clean();
    test_xor_stuck0();
    test_saturate();
    test_and_stuck1();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
Self-checking sequencer that drives the two inputs of the two-input logic gates block and consumes its seven gate outputs. On a start pulse it steps through all four input vectors in the order 00, 01, 10, 11. For each vector it waits a settle interval, then compares the returned outputs against internally computed expected values. It accumulates a saturating error count and records the first failure. Used as an on-chip / bench-level sweep stage around the gate block.

Parameters:
SETTLE_CYCLES, 2, cycles spent in SETTLE per vector; legal range >=1
NUM_PASSES, 1, number of full 4-vector sweeps per start; legal range >=1
CNT_W, 8, width of err_count

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  begin sweep; sampled only in IDLE
a_out  output  1  drives gate block input a
b_out  output  1  drives gate block input b
gate_in  input  7  returned outputs; bit6 AND, 5 OR, 4 NOT, 3 NAND, 2 NOR, 1 XOR, 0 XNOR
busy  output  1  high from start acceptance until DONE
done  output  1  one-cycle completion pulse
pass  output  1  high when last completed run had zero mismatches
err_count  output  CNT_W  mismatching vectors in last/current run, saturating
first_fail_vec  output  2  {a,b} of first mismatching vector
first_fail_mask  output  7  XOR of expected vs gate_in at first mismatch

Behaviour:
- Reset (synchronous, active-high): state=IDLE. a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_mask=0. Reset overrides all activity, including mid-sweep.
- Expected values: AND=a&b, OR=a|b, NOT=~a, NAND=~(a&b), NOR=~(a|b), XOR=a^b, XNOR=~(a^b).
- States: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered.
- IDLE: if start=1, then on that edge:
  - {a_out,b_out}=00, vector=0, pass_idx=0, settle_cnt=0
  - err_count, first_fail_* and pass cleared; busy=1
  - go to SETTLE
- SETTLE: settle_cnt increments each edge. When settle_cnt==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE (one cycle): compare gate_in with expected for the current vector.
  - On mismatch: err_count increments, saturating at 2^CNT_W-1. If this is the first mismatch of the run, latch first_fail_vec and first_fail_mask.
  - If vector==3 and pass_idx==NUM_PASSES-1: go to DONE.
  - Otherwise: vector increments, wrapping 3->0 and incrementing pass_idx on wrap. a_out/b_out update on the same edge, settle_cnt=0, go to SETTLE.
- Per-vector cost is SETTLE_CYCLES+1 edges. done is high during the cycle after edge number 4*(SETTLE_CYCLES+1)*NUM_PASSES, counted from the edge that accepted start.
- DONE (one cycle): done=1, busy=0. pass=1 iff err_count==0. a_out/b_out hold their last vector. Go to IDLE.
- After DONE, pass, err_count and first_fail_* hold until the next accepted start or reset.
- start is ignored while busy, including a start asserted during the DONE cycle.
- gate_in is treated as combinational from a_out/b_out. No sampling of gate_in occurs outside SAMPLE.

Optional Feature:
Macro GATE_SWEEP_ABORT_ON_FAIL_EN.
- Defined: the first mismatch in SAMPLE goes directly to DONE. err_count=1, pass=0, and remaining vectors and passes are skipped.
- Undefined: the full sweep always completes, as described above.

Test Plan:
- Correct gate model, defaults, start pulse at cycle 0 -> a/b step 00,01,10,11 every 3 cycles; done pulse 12 cycles after acceptance; pass=1, err_count=0, busy low after done.
- XOR output stuck at 0 -> mismatches on vectors 01 and 10; err_count=2, pass=0, first_fail_vec=01, first_fail_mask=0000010.
- NUM_PASSES=3, CNT_W=2, NOT output stuck at 1 -> 6 raw mismatches; err_count saturates at 3; first_fail_vec=10, first_fail_mask=0010000.
- start held high continuously during a sweep -> exactly one run; a second run starts only from IDLE after done; start during the DONE cycle is ignored.
- rst asserted at the SAMPLE of vector 10 -> next cycle all outputs at reset values, state IDLE; a subsequent start runs a clean full sweep.
- GATE_SWEEP_ABORT_ON_FAIL_EN defined, AND output stuck at 1 -> done in the cycle after the first SAMPLE (vector 00); err_count=1, first_fail_mask=1000000.
